alsu_result_fifo: RTL and testbench

Result-capture stage directly downstream of the ALSU. On each cycle its capture strobe is high, it samples the ALSU's registered `out` and `leds` outputs, tags the sample with a sequence number, and buffers it in a FIFO. The bench or a checker drains the FIFO through a valid/ready port. Overflow and invalid-operation events are tracked so no result is silently lost.

---
 rtl/alsu_result_fifo.sv | 169 ++++++++++++++++
 tb/tb_alsu_result_fifo.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/alsu_result_fifo.sv
// alsu_result_fifo
// ----------------
// Result-capture FIFO directly downstream of the ALSU. On every cycle cap_en is
// high, the ALSU's registered out/leds values are sampled, tagged with a
// sequence number and queued. A consumer drains the queue through a
// first-word-fall-through valid/ready port. Dropped captures (queue full, no
// pop in the same cycle) are never silent: they set the sticky overflow flag
// and bump a saturating drop counter.
//
// Parameters
//   DEPTH   FIFO entries (power of two, >= 2)
//   TAG_W   sequence-tag width; the tag wraps modulo 2^TAG_W
//
// Ports
//   clk       clock, all state updates on the rising edge
//   rst       synchronous active-high reset
//   clr       synchronous soft clear, same effect as rst (rst has priority)
//   cap_en    capture strobe
//   out_in    ALSU out (6 bits)
//   leds_in   ALSU leds (16 bits); non-zero marks an invalid operation
//   rd_valid  head entry available
//   rd_ready  consumer accepts the head entry
//   rd_out    head entry result value
//   rd_err    head entry invalid-op flag
//   rd_tag    head entry sequence tag
//   level     occupancy, 0..DEPTH
//   full      level == DEPTH
//   overflow  sticky: at least one capture was dropped
//   drop_cnt  dropped captures, saturating at 255
//   err_cnt   captures with leds_in != 0, saturating at 0xFFFF
//             (only when ALSU_RES_ERR_CNT_EN is defined)
//
// Optional feature macro: ALSU_RES_ERR_CNT_EN adds the err_cnt port and logic.

module alsu_result_fifo #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       cap_en,
  input  logic [5:0]                 out_in,
  input  logic [15:0]                leds_in,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [5:0]                 rd_out,
  output logic                       rd_err,
  output logic [TAG_W-1:0]           rd_tag,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       overflow,
  output logic [7:0]                 drop_cnt
`ifdef ALSU_RES_ERR_CNT_EN
  ,
  output logic [15:0]                err_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  // Entry layout: {err, out[5:0], tag}
  localparam int EW = TAG_W + 7;

  logic [EW-1:0]    mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [TAG_W-1:0] tag_r;
  logic [PW-1:0]    level_r;
  logic             full_r;
  logic             valid_r;
  logic             overflow_r;
  logic [7:0]       drop_cnt_r;

  logic             pop_s;
  logic             push_s;
  logic             drop_s;
  logic             err_s;
  logic [PW-1:0]    wr_ptr_nxt_s;
  logic [PW-1:0]    rd_ptr_nxt_s;
  logic [PW-1:0]    level_nxt_s;
  logic [EW-1:0]    head_s;

  // Handshake decode and next pointer / occupancy computation.
  always_comb begin
    pop_s        = valid_r && rd_ready;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    push_s       = cap_en && (!full_r || pop_s);
    drop_s       = cap_en && full_r && !pop_s;
    err_s        = (leds_in != 16'h0000);
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    if (push_s) begin
      wr_ptr_nxt_s = wr_ptr_r + PW'(1);
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end
    if (pop_s) begin
      rd_ptr_nxt_s = rd_ptr_r + PW'(1);
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
    // Extra wrap bit makes the plain difference range over 0..DEPTH.
    level_nxt_s  = wr_ptr_nxt_s - rd_ptr_nxt_s;
  end

  // Pointer, tag, status and drop-counter registers.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr_r   <= {PW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
      tag_r      <= {TAG_W{1'b0}};
      level_r    <= {PW{1'b0}};
      full_r     <= 1'b0;
      valid_r    <= 1'b0;
      overflow_r <= 1'b0;
      drop_cnt_r <= 8'h00;
    end else begin
      wr_ptr_r   <= wr_ptr_nxt_s;
      rd_ptr_r   <= rd_ptr_nxt_s;
      level_r    <= level_nxt_s;
      full_r     <= (level_nxt_s == PW'(DEPTH));
      valid_r    <= (level_nxt_s != {PW{1'b0}});
      if (push_s) begin
        tag_r <= tag_r + {{(TAG_W-1){1'b0}}, 1'b1};
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
        if (drop_cnt_r != 8'hFF) begin
          drop_cnt_r <= drop_cnt_r + 8'd1;
        end
      end
    end
  end

  // Entry storage; contents survive reset, only the pointers are cleared.
  always_ff @(posedge clk) begin
    if (push_s && !rst && !clr) begin
      mem_r[wr_ptr_r[AW-1:0]] <= {err_s, out_in, tag_r};
    end
  end

`ifdef ALSU_RES_ERR_CNT_EN
  logic [15:0] err_cnt_r;

  // Invalid-op counter: counts every flagged capture, accepted or dropped.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      err_cnt_r <= 16'h0000;
    end else if (cap_en && err_s && (err_cnt_r != 16'hFFFF)) begin
      err_cnt_r <= err_cnt_r + 16'd1;
    end
  end

  assign err_cnt = err_cnt_r;
`endif

  // First-word-fall-through view of the head entry.
  assign head_s   = mem_r[rd_ptr_r[AW-1:0]];
  assign rd_err   = head_s[EW-1];
  assign rd_out   = head_s[TAG_W +: 6];
  assign rd_tag   = head_s[TAG_W-1:0];
  assign rd_valid = valid_r;
  assign level    = level_r;
  assign full     = full_r;
  assign overflow = overflow_r;
  assign drop_cnt = drop_cnt_r;

endmodule

// File: tb/tb_alsu_result_fifo.sv
// Self-checking bench for alsu_result_fifo (DEPTH=8, TAG_W=8).
// A table of single-cycle vectors covers basic capture/drain and the rd_err
// flag; hand-written sequences cover overflow, full push+pop, clear/reset
// mid-stream and tag wrap-around.

module tb_alsu_result_fifo;

  logic        clk;
  logic        rst;
  logic        clr;
  logic        cap_en;
  logic [5:0]  out_in;
  logic [15:0] leds_in;
  logic        rd_valid;
  logic        rd_ready;
  logic [5:0]  rd_out;
  logic        rd_err;
  logic [7:0]  rd_tag;
  logic [3:0]  level;
  logic        full;
  logic        overflow;
  logic [7:0]  drop_cnt;
`ifdef ALSU_RES_ERR_CNT_EN
  logic [15:0] err_cnt;
`endif

  int n_checks;
  int n_fail;

  alsu_result_fifo #(.DEPTH(8), .TAG_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .cap_en   (cap_en),
    .out_in   (out_in),
    .leds_in  (leds_in),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_out   (rd_out),
    .rd_err   (rd_err),
    .rd_tag   (rd_tag),
    .level    (level),
    .full     (full),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
`ifdef ALSU_RES_ERR_CNT_EN
    ,
    .err_cnt  (err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        cap;
    logic [5:0]  o;
    logic [15:0] l;
    logic        rdy;
    logic        e_valid;
    logic [5:0]  e_out;
    logic        e_err;
    logic [7:0]  e_tag;
    logic [3:0]  e_level;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive inputs away from the edge, clock once, sample just after the edge.
  task automatic step(input logic cap, input logic [5:0] o, input logic [15:0] l, input logic rdy);
    @(negedge clk);
    rst      = 1'b0;
    clr      = 1'b0;
    cap_en   = cap;
    out_in   = o;
    leds_in  = l;
    rd_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  // One-cycle rst or clr pulse with a push and a pop requested in the same cycle.
  task automatic pulse(input logic use_rst);
    @(negedge clk);
    rst      = use_rst;
    clr      = ~use_rst;
    cap_en   = 1'b1;
    out_in   = 6'd33;
    leds_in  = 16'h0000;
    rd_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_valid"},    32'(rd_valid), 32'd0);
    chk({tag, "_level"},    32'(level),    32'd0);
    chk({tag, "_full"},     32'(full),     32'd0);
    chk({tag, "_overflow"}, 32'(overflow), 32'd0);
    chk({tag, "_drop_cnt"}, 32'(drop_cnt), 32'd0);
`ifdef ALSU_RES_ERR_CNT_EN
    chk({tag, "_err_cnt"},  32'(err_cnt),  32'd0);
`endif
  endtask

  task automatic do_reset();
    pulse(1'b1);
    step(1'b0, 6'd0, 16'h0000, 1'b0);
  endtask

  // Queue 4 entries with overflow set, then clear via rst or clr.
  task automatic clear_test(input logic use_rst, input string tag);
    do_reset();
    for (int i = 0; i < 9; i++) step(1'b1, 6'(i), 16'hFFFF, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 6'd0, 16'h0000, 1'b1);
    chk({tag, "_pre_level"},    32'(level),    32'd4);
    chk({tag, "_pre_overflow"}, 32'(overflow), 32'd1);
    chk({tag, "_pre_drop"},     32'(drop_cnt), 32'd1);
    pulse(use_rst);
    check_cleared(tag);
    step(1'b1, 6'd9, 16'h0000, 1'b0);
    chk({tag, "_next_valid"}, 32'(rd_valid), 32'd1);
    chk({tag, "_next_tag"},   32'(rd_tag),   32'd0);
    chk({tag, "_next_out"},   32'(rd_out),   32'd9);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1; clr = 1'b0; cap_en = 1'b0; out_in = 6'd0; leds_in = 16'h0000; rd_ready = 1'b0;

    //            cap   out    leds      rdy   valid out    err   tag   level
    vecs[0] = '{1'b1, 6'd5,  16'h0000, 1'b1, 1'b1, 6'd5,  1'b0, 8'd0, 4'd1};
    vecs[1] = '{1'b1, 6'd12, 16'h0000, 1'b1, 1'b1, 6'd12, 1'b0, 8'd1, 4'd1};
    vecs[2] = '{1'b1, 6'd63, 16'h0000, 1'b1, 1'b1, 6'd63, 1'b0, 8'd2, 4'd1};
    vecs[3] = '{1'b0, 6'd0,  16'h0000, 1'b1, 1'b0, 6'd0,  1'b0, 8'd0, 4'd0};
    vecs[4] = '{1'b1, 6'd1,  16'hFFFF, 1'b0, 1'b1, 6'd1,  1'b1, 8'd3, 4'd1};
    vecs[5] = '{1'b1, 6'd2,  16'h0000, 1'b0, 1'b1, 6'd1,  1'b1, 8'd3, 4'd2};
    vecs[6] = '{1'b1, 6'd3,  16'hFFFF, 1'b0, 1'b1, 6'd1,  1'b1, 8'd3, 4'd3};
    vecs[7] = '{1'b0, 6'd0,  16'h0000, 1'b1, 1'b1, 6'd2,  1'b0, 8'd4, 4'd2};
    vecs[8] = '{1'b0, 6'd0,  16'h0000, 1'b1, 1'b1, 6'd3,  1'b1, 8'd5, 4'd1};
    vecs[9] = '{1'b0, 6'd0,  16'h0000, 1'b1, 1'b0, 6'd0,  1'b0, 8'd0, 4'd0};

    // Reset state
    do_reset();
    check_cleared("reset");

    // Table: basic capture/drain and rd_err flag
    for (int i = 0; i < 10; i++) begin
      step(vecs[i].cap, vecs[i].o, vecs[i].l, vecs[i].rdy);
      chk($sformatf("vec%0d_valid", i), 32'(rd_valid), 32'(vecs[i].e_valid));
      chk($sformatf("vec%0d_level", i), 32'(level),    32'(vecs[i].e_level));
      chk($sformatf("vec%0d_full", i),  32'(full),     32'd0);
      if (vecs[i].e_valid) begin
        chk($sformatf("vec%0d_out", i), 32'(rd_out), 32'(vecs[i].e_out));
        chk($sformatf("vec%0d_err", i), 32'(rd_err), 32'(vecs[i].e_err));
        chk($sformatf("vec%0d_tag", i), 32'(rd_tag), 32'(vecs[i].e_tag));
      end
    end
    chk("tbl_overflow", 32'(overflow), 32'd0);
`ifdef ALSU_RES_ERR_CNT_EN
    chk("tbl_err_cnt", 32'(err_cnt), 32'd2);
`endif

    // Overflow: 10 captures into an 8-deep FIFO with no drain
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 6'(i), 16'h0000, 1'b0);
      if (i == 7) begin
        chk("ovf_full8",  32'(full),  32'd1);
        chk("ovf_level8", 32'(level), 32'd8);
        chk("ovf_noflag", 32'(overflow), 32'd0);
      end
    end
    chk("ovf_flag",  32'(overflow), 32'd1);
    chk("ovf_drops", 32'(drop_cnt), 32'd2);
    chk("ovf_level", 32'(level),    32'd8);

    // Full with simultaneous capture and pop
    step(1'b1, 6'd40, 16'h0000, 1'b1);
    chk("fpp_level", 32'(level),    32'd8);
    chk("fpp_full",  32'(full),     32'd1);
    chk("fpp_drops", 32'(drop_cnt), 32'd2);
    chk("fpp_tag",   32'(rd_tag),   32'd1);

    // Drain: tags 1..8, no tag from a dropped capture
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("drain%0d_valid", k), 32'(rd_valid), 32'd1);
      chk($sformatf("drain%0d_tag", k),   32'(rd_tag),   32'(k + 1));
      chk($sformatf("drain%0d_out", k),   32'(rd_out),   (k < 7) ? 32'(k + 1) : 32'd40);
      step(1'b0, 6'd0, 16'h0000, 1'b1);
    end
    chk("drain_valid",    32'(rd_valid), 32'd0);
    chk("drain_level",    32'(level),    32'd0);
    chk("drain_sticky",   32'(overflow), 32'd1);

    // Mid-stream clear and reset
    clear_test(1'b0, "clr");
    clear_test(1'b1, "rst");

    // Tag wrap with continuous drain
    do_reset();
    for (int k = 0; k < 260; k++) begin
      step(1'b1, 6'(k), 16'h0000, 1'b1);
      chk($sformatf("wrap%0d_tag", k),   32'(rd_tag), 32'(k % 256));
      chk($sformatf("wrap%0d_level", k), 32'(level),  32'd1);
    end
    step(1'b0, 6'd0, 16'h0000, 1'b1);
    chk("wrap_end_level", 32'(level),    32'd0);
    chk("wrap_end_drops", 32'(drop_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
